// File: rtl/voice_pkg.sv
// Shared types for the voice allocator.
//   voice_state_t : lifecycle of one notebank voice
//   alloc_state_t : allocator FSM states
//   scan_result_t : candidates gathered while walking the voice bank
package voice_pkg;

  // Voice indices are carried at a fixed width so the scan record does not
  // depend on NUM_VOICES (2..16).
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    V_FREE,
    V_HELD,
    V_REL
  } voice_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_STEAL
  } alloc_state_t;

  typedef struct packed {
    logic             match_vld;   // some non-free voice carries the event key
    logic             match_held;  // that voice was V_HELD when scanned
    logic [IDX_W-1:0] match_idx;
    logic             free_vld;    // first V_FREE voice
    logic [IDX_W-1:0] free_idx;
    logic             rel_vld;     // oldest V_REL voice
    logic [IDX_W-1:0] rel_idx;
    logic             held_vld;    // oldest V_HELD voice (steal victim)
    logic [IDX_W-1:0] held_idx;
  } scan_result_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Key-event bus between the front end and the voice allocator.
//   ev_valid/ev_ready : handshake. An event transfers on a rising clock edge
//                       where ev_valid & ev_ready are both high. The source
//                       holds ev_on/ev_key/ev_period stable while
//                       ev_valid & !ev_ready; ev_ready never depends on
//                       ev_valid.
//   ev_on             : 1 = note-on, 0 = note-off
//   ev_key            : key number
//   ev_period         : tone period (note-on only)
interface voice_allocator_if #(
  parameter int KEY_W    = 7,
  parameter int PERIOD_W = 23
);
  logic                ev_valid;
  logic                ev_ready;
  logic                ev_on;
  logic [KEY_W-1:0]    ev_key;
  logic [PERIOD_W-1:0] ev_period;

  modport master (output ev_valid, ev_on, ev_key, ev_period, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_key, ev_period, output ev_ready);
endinterface

// File: rtl/voice_slot.sv
// One voice's bookkeeping: lifecycle state, key, saturating age, period.
//   load/load_key/load_period : note-on assignment to this voice
//   age_inc                   : some voice took a note-on this cycle
//   release_req               : note-off accepted for this voice
//   done                      : notebank release finished (level)
//   state/key/age/period      : current values; period shows load_period
//                               in the load cycle so it lines up with note_on
module voice_slot
  import voice_pkg::*;
#(
  parameter int KEY_W    = 7,
  parameter int PERIOD_W = 23,
  parameter int AGE_W    = 8
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                load,
  input  logic [KEY_W-1:0]    load_key,
  input  logic [PERIOD_W-1:0] load_period,
  input  logic                age_inc,
  input  logic                release_req,
  input  logic                done,
  output voice_state_t        state,
  output logic [KEY_W-1:0]    key,
  output logic [AGE_W-1:0]    age,
  output logic [PERIOD_W-1:0] period
);

  logic [PERIOD_W-1:0] period_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= V_FREE;
      key      <= '0;
      age      <= '0;
      period_q <= '0;
    end else if (load) begin
      // Assignment beats a simultaneous done: the voice ends up held.
      state    <= V_HELD;
      key      <= load_key;
      age      <= '0;
      period_q <= load_period;
    end else begin
      if (release_req) begin
        state <= V_REL;
      end else if (state == V_REL && done) begin
        state <= V_FREE;
      end
      if (age_inc && state != V_FREE && age != '1) begin
        age <= age + 1'b1;
      end
    end
  end

  assign period = load ? load_period : period_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler. Accepts key events, walks the voice bank one
// voice per cycle, then starts, retriggers, reuses or steals a voice.
//   clk, rst_b        : clock, async active-low reset
//   ev                : key-event bus (slave side)
//   voice_done        : per-voice release finished
//   voice_note_on/off : one-cycle pulses per voice
//   voice_period      : voice i at [i*PERIOD_W +: PERIOD_W]
//   busy              : FSM not idle
//   fsm_state         : current FSM state (debug)
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7,
  parameter int PERIOD_W   = 23,
  parameter int AGE_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst_b,
  voice_allocator_if.slave               ev,
  input  logic [NUM_VOICES-1:0]          voice_done,
  output logic [NUM_VOICES-1:0]          voice_note_on,
  output logic [NUM_VOICES-1:0]          voice_note_off,
  output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  output logic                           busy,
  output alloc_state_t                   fsm_state
);

  alloc_state_t        state_q, state_d;
  scan_result_t        cand_q, cand_d;
  logic [IDX_W-1:0]    idx_q;
  logic                lat_on;
  logic [KEY_W-1:0]    lat_key;
  logic [PERIOD_W-1:0] lat_period;

  voice_state_t        slot_state  [NUM_VOICES];
  logic [KEY_W-1:0]    slot_key    [NUM_VOICES];
  logic [AGE_W-1:0]    slot_age    [NUM_VOICES];
  logic [PERIOD_W-1:0] slot_period [NUM_VOICES];

  logic [NUM_VOICES-1:0] on_vec, off_vec, rel_vec;
  logic                  do_on, do_off, do_rel;
  logic [IDX_W-1:0]      on_idx, off_idx;

  // Live view of the voice under scan and of the current best candidates.
  // Ages only change on a note-on, which cannot happen mid-scan, so reading
  // the candidates' ages live is equivalent to having stored them.
  voice_state_t     cur_state;
  logic [KEY_W-1:0] cur_key;
  logic [AGE_W-1:0] cur_age, rel_age_best, held_age_best;

  always_comb begin
    cur_state     = V_FREE;
    cur_key       = '0;
    cur_age       = '0;
    rel_age_best  = '0;
    held_age_best = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_state = slot_state[i];
        cur_key   = slot_key[i];
        cur_age   = slot_age[i];
      end
      if (IDX_W'(i) == cand_q.rel_idx)  rel_age_best  = slot_age[i];
      if (IDX_W'(i) == cand_q.held_idx) held_age_best = slot_age[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    ev.ev_ready = 1'b0;
    do_on       = 1'b0;
    do_off      = 1'b0;
    do_rel      = 1'b0;
    on_idx      = '0;
    off_idx     = '0;
    case (state_q)
      S_IDLE: begin
        ev.ev_ready = 1'b1;
        if (ev.ev_valid) begin
          state_d = S_SCAN;
          cand_d  = '0;
        end
      end
      S_SCAN: begin
        if (!cand_q.match_vld && cur_state != V_FREE && cur_key == lat_key) begin
          cand_d.match_vld  = 1'b1;
          cand_d.match_held = (cur_state == V_HELD);
          cand_d.match_idx  = idx_q;
        end
        if (!cand_q.free_vld && cur_state == V_FREE) begin
          cand_d.free_vld = 1'b1;
          cand_d.free_idx = idx_q;
        end
        // Strict compare: on equal ages the lower index already recorded wins.
        if (cur_state == V_REL && (!cand_q.rel_vld || cur_age > rel_age_best)) begin
          cand_d.rel_vld = 1'b1;
          cand_d.rel_idx = idx_q;
        end
        if (cur_state == V_HELD && (!cand_q.held_vld || cur_age > held_age_best)) begin
          cand_d.held_vld = 1'b1;
          cand_d.held_idx = idx_q;
        end
        if (idx_q == IDX_W'(NUM_VOICES - 1)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_IDLE;
        if (lat_on) begin
          if (cand_q.match_vld) begin
            do_on  = 1'b1;
            on_idx = cand_q.match_idx;
          end else if (cand_q.free_vld) begin
            do_on  = 1'b1;
            on_idx = cand_q.free_idx;
          end else if (cand_q.rel_vld) begin
            do_on  = 1'b1;
            on_idx = cand_q.rel_idx;
          end else if (cand_q.held_vld) begin
            // Steal: release now, restart next cycle with the new period.
            do_off  = 1'b1;
            off_idx = cand_q.held_idx;
            state_d = S_STEAL;
          end
        end else if (cand_q.match_vld && cand_q.match_held) begin
          do_off  = 1'b1;
          do_rel  = 1'b1;
          off_idx = cand_q.match_idx;
        end
      end
      S_STEAL: begin
        state_d = S_IDLE;
        do_on   = 1'b1;
        on_idx  = cand_q.held_idx;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    on_vec  = '0;
    off_vec = '0;
    rel_vec = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      on_vec[i]  = do_on  && (IDX_W'(i) == on_idx);
      off_vec[i] = do_off && (IDX_W'(i) == off_idx);
      rel_vec[i] = do_rel && (IDX_W'(i) == off_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      idx_q      <= '0;
      lat_on     <= 1'b0;
      lat_key    <= '0;
      lat_period <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      if (state_q == S_SCAN) idx_q <= idx_q + 1'b1;
      else                   idx_q <= '0;
      if (state_q == S_IDLE && ev.ev_valid) begin
        lat_on     <= ev.ev_on;
        lat_key    <= ev.ev_key;
        lat_period <= ev.ev_period;
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .KEY_W   (KEY_W),
      .PERIOD_W(PERIOD_W),
      .AGE_W   (AGE_W)
    ) u_slot (
      .clk        (clk),
      .rst_b      (rst_b),
      .load       (on_vec[g]),
      .load_key   (lat_key),
      .load_period(lat_period),
      .age_inc    (do_on),
      .release_req(rel_vec[g]),
      .done       (voice_done[g]),
      .state      (slot_state[g]),
      .key        (slot_key[g]),
      .age        (slot_age[g]),
      .period     (slot_period[g])
    );
    assign voice_period[g*PERIOD_W +: PERIOD_W] = slot_period[g];
  end

  assign voice_note_on  = on_vec;
  assign voice_note_off = off_vec;
  assign busy           = (state_q != S_IDLE);
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (4 voices). Each scenario pushes
// the pulses it expects into exp_q; the event driver records every observed
// pulse into obs_q as {cycle offset, is_off, voice vector, period}.
module tb_voice_allocator;
  import voice_pkg::*;

  localparam int NV = 4;
  localparam int KW = 7;
  localparam int PW = 23;
  localparam int AW = 8;
  localparam int W  = 4 + 1 + NV + PW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  voice_allocator_if #(.KEY_W(KW), .PERIOD_W(PW)) ev ();
  logic [NV-1:0]    voice_done;
  logic [NV-1:0]    voice_note_on;
  logic [NV-1:0]    voice_note_off;
  logic [NV*PW-1:0] voice_period;
  logic             busy;
  alloc_state_t     fsm_state;

  voice_allocator #(
    .NUM_VOICES(NV), .KEY_W(KW), .PERIOD_W(PW), .AGE_W(AW)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .ev            (ev),
    .voice_done    (voice_done),
    .voice_note_on (voice_note_on),
    .voice_note_off(voice_note_off),
    .voice_period  (voice_period),
    .busy          (busy),
    .fsm_state     (fsm_state)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] enc(input int k, input logic is_off,
                                       input logic [NV-1:0] v, input logic [PW-1:0] p);
    return {4'(k), is_off, v, p};
  endfunction

  task automatic apply_reset();
    rst_b       = 1'b0;
    voice_done  = '0;
    ev.ev_valid = 1'b0;
    ev.ev_on    = 1'b0;
    ev.ev_key   = '0;
    ev.ev_period = '0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic record_pulses(input int k);
    logic [PW-1:0] pv;
    if (voice_note_off != '0) obs_q.push_back(enc(k, 1'b1, voice_note_off, '0));
    if (voice_note_on != '0) begin
      pv = '0;
      for (int i = 0; i < NV; i++)
        if (voice_note_on[i]) pv = voice_period[i*PW +: PW];
      obs_q.push_back(enc(k, 1'b0, voice_note_on, pv));
    end
  endtask

  task automatic send_ev(input logic on, input logic [KW-1:0] key,
                         input logic [PW-1:0] per, output int rdy_at);
    int waited = 0;
    @(negedge clk);
    while (!ev.ev_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ev.ev_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: ev_ready=%b required 1", ev.ev_ready);
    end
    ev.ev_valid  = 1'b1;
    ev.ev_on     = on;
    ev.ev_key    = key;
    ev.ev_period = per;
    @(posedge clk);
    #1 ev.ev_valid = 1'b0;
    rdy_at = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      record_pulses(k);
      if (rdy_at < 0 && ev.ev_ready) rdy_at = k;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    total++; if (ev.ev_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ev.ev_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (voice_note_on !== '0 || voice_note_off !== '0) begin
      bad++; $display("FAIL reset_pulses: on=%b off=%b want 0", voice_note_on, voice_note_off); end
    total++; if (voice_period !== '0) begin bad++; $display("FAIL reset_period: got %h want 0", voice_period); end
    total++; if (fsm_state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_IDLE); end
  endtask

  task automatic test_first_note();
    int rdy;
    logic [W-1:0] e, o;
    apply_reset();
    exp_q.push_back(enc(5, 1'b0, 4'b0001, 23'd1000));
    send_ev(1'b1, 7'd60, 23'd1000, rdy);
    total++; if (rdy !== 6) begin bad++; $display("FAIL first_ready: got %0d want 6", rdy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL first_pulse: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL first_pulse: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL first_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_steal();
    int rdy;
    logic [W-1:0] e, o;
    logic [PW-1:0] p [5];
    logic [KW-1:0] keys [5] = '{7'd60, 7'd62, 7'd64, 7'd65, 7'd67};
    apply_reset();
    for (int i = 0; i < 5; i++) p[i] = PW'($urandom_range(1, 8000000));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(enc(5, 1'b0, NV'(1 << i), p[i]));
      send_ev(1'b1, keys[i], p[i], rdy);
    end
    exp_q.push_back(enc(5, 1'b1, 4'b0001, '0));
    exp_q.push_back(enc(6, 1'b0, 4'b0001, p[4]));
    send_ev(1'b1, keys[4], p[4], rdy);
    total++; if (rdy !== 7) begin bad++; $display("FAIL steal_ready: got %0d want 7", rdy); end
    total++; if (voice_period[PW +: PW] !== p[1]) begin
      bad++; $display("FAIL steal_other_period: got %0d want %0d", voice_period[PW +: PW], p[1]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL steal_pulse: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL steal_pulse: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL steal_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_release_reuse();
    int rdy;
    logic [W-1:0] e, o;
    logic [PW-1:0] p;
    apply_reset();
    p = PW'($urandom_range(1, 8000000));
    exp_q.push_back(enc(5, 1'b0, 4'b0001, p));  send_ev(1'b1, 7'd60, p, rdy);
    exp_q.push_back(enc(5, 1'b1, 4'b0001, '0)); send_ev(1'b0, 7'd60, '0, rdy);
    // Voice 0 is releasing; a free voice is preferred over it.
    exp_q.push_back(enc(5, 1'b0, 4'b0010, 23'd620)); send_ev(1'b1, 7'd62, 23'd620, rdy);
    exp_q.push_back(enc(5, 1'b0, 4'b0100, 23'd640)); send_ev(1'b1, 7'd64, 23'd640, rdy);
    exp_q.push_back(enc(5, 1'b0, 4'b1000, 23'd650)); send_ev(1'b1, 7'd65, 23'd650, rdy);
    // Bank full: reuse the releasing voice without a note_off.
    exp_q.push_back(enc(5, 1'b0, 4'b0001, 23'd700)); send_ev(1'b1, 7'd70, 23'd700, rdy);
    exp_q.push_back(enc(5, 1'b1, 4'b0010, '0)); send_ev(1'b0, 7'd62, '0, rdy);
    exp_q.push_back(enc(5, 1'b1, 4'b0100, '0)); send_ev(1'b0, 7'd64, '0, rdy);
    // Voice 1 is the older releaser, but done frees voice 2 first.
    voice_done = 4'b0100;
    exp_q.push_back(enc(5, 1'b0, 4'b0100, 23'd800)); send_ev(1'b1, 7'd80, 23'd800, rdy);
    voice_done = '0;
    // Note-off of a key that is only releasing is dropped.
    send_ev(1'b0, 7'd62, '0, rdy);
    total++; if (rdy !== 6) begin bad++; $display("FAIL rel_drop_ready: got %0d want 6", rdy); end
    exp_q.push_back(enc(5, 1'b0, 4'b0010, 23'd820)); send_ev(1'b1, 7'd82, 23'd820, rdy);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL reuse_pulse: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL reuse_pulse: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL reuse_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_drop_off();
    int rdy;
    apply_reset();
    send_ev(1'b0, 7'd50, '0, rdy);
    total++; if (rdy !== 6) begin bad++; $display("FAIL drop_ready: got %0d want 6", rdy); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL drop_extra: got %0d pulses want 0", obs_q.size()); end
  endtask

  task automatic test_retrigger();
    int rdy;
    logic [W-1:0] e, o;
    logic [KW-1:0] keys [4] = '{7'd60, 7'd62, 7'd64, 7'd65};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(enc(5, 1'b0, NV'(1 << i), PW'(100 * (i + 1))));
      send_ev(1'b1, keys[i], PW'(100 * (i + 1)), rdy);
    end
    exp_q.push_back(enc(5, 1'b0, 4'b0001, 23'd1111));
    send_ev(1'b1, 7'd60, 23'd1111, rdy);
    total++; if (rdy !== 6) begin bad++; $display("FAIL retrig_ready: got %0d want 6", rdy); end
    // Voice 0's age was cleared, so voice 1 is now the oldest.
    exp_q.push_back(enc(5, 1'b1, 4'b0010, '0));
    exp_q.push_back(enc(6, 1'b0, 4'b0010, 23'd6767));
    send_ev(1'b1, 7'd67, 23'd6767, rdy);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL retrig_pulse: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL retrig_pulse: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL retrig_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_scan();
    int rdy;
    logic [W-1:0] e, o;
    apply_reset();
    @(negedge clk);
    ev.ev_valid = 1'b1; ev.ev_on = 1'b1; ev.ev_key = 7'd60; ev.ev_period = 23'd4242;
    @(posedge clk);
    #1 ev.ev_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst_b = 1'b0;
    #1;
    total++; if (ev.ev_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_hs: ready=%b busy=%b want 1 0", ev.ev_ready, busy); end
    total++; if (voice_note_on !== '0 || voice_note_off !== '0 || voice_period !== '0) begin
      bad++; $display("FAIL mid_reset_out: on=%b off=%b period=%h want 0", voice_note_on, voice_note_off, voice_period); end
    @(negedge clk);
    rst_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      record_pulses(k);
    end
    total++; if (ev.ev_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after: got %b want 1", ev.ev_ready); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_stray: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
    exp_q.push_back(enc(5, 1'b0, 4'b0001, 23'd6161));
    send_ev(1'b1, 7'd61, 23'd6161, rdy);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL mid_after_pulse: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL mid_after_pulse: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_after_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  // ---------------- main + report ----------------
  initial begin
    test_reset();
    test_first_note();
    test_steal();
    test_release_reuse();
    test_drop_off();
    test_retrigger();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler sitting between the key-event front end and a bank of `NUM_VOICES` notebank instances. Accepts note-on/note-off events via a valid/ready handshake and assigns each note to a voice. Drives each voice's `note_on`/`note_off` pulses and `period`, and steals the oldest voice when all are busy. Tracks each voice's lifecycle (free, held, releasing) using the per-voice `done` feedback.

## Interface
- `NUM_VOICES`, default 4: number of notebank voices driven; range 2..16.
- `KEY_W`, default 7: key-number width.
- `PERIOD_W`, default 23: period width, matching the notebank `period` input.
- `AGE_W`, default 8: per-voice age counter width; ages saturate.

Ports:
- `clk  in  1`: single clock. All logic is on the rising edge.
- `rst_b  in  1`: asynchronous, active-low reset.
- `ev_valid  in  1`: event offered.
- `ev_ready  out  1`: allocator can accept an event.
- `ev_on  in  1`: 1 = note-on, 0 = note-off.
- `ev_key  in  KEY_W`: key number.
- `ev_period  in  PERIOD_W`: tone period for note-on; ignored for note-off.
- `voice_done  in  NUM_VOICES`: per-voice release-finished, level-sensitive.
- `voice_note_on  out  NUM_VOICES`: one-cycle start pulse per voice.
- `voice_note_off  out  NUM_VOICES`: one-cycle release pulse per voice.
- `voice_period  out  NUM_VOICES*PERIOD_W`: voice i occupies bits `[i*PERIOD_W +: PERIOD_W]`.
- `busy  out  1`: high whenever the FSM is not in `S_IDLE`.

## Operation
- Each voice holds a state (`V_FREE`, `V_HELD`, `V_REL`), a key, and an age.
- A voice in `V_REL` with `voice_done[i]`=1 moves to `V_FREE`.
- `voice_done` is ignored in `V_FREE` and `V_HELD`.
- FSM states:
  - `S_IDLE`: `ev_ready`=1. An event is accepted on `ev_valid & ev_ready`, which latches `ev_on`, `ev_key` and `ev_period`.
  - `S_SCAN`: examines one voice per cycle, index 0..N-1, and records:
    - the first key match (`V_HELD` or `V_REL` with the same key);
    - the first `V_FREE` voice;
    - the oldest `V_REL` voice;
    - the oldest `V_HELD` voice.
    - Among equal ages, the lower index wins.
  - `S_ISSUE`: acts on the scan result (see below).
  - `S_STEAL`: pulses `voice_note_on` on the stolen voice, then returns to `S_IDLE`.
- Note-on target priority, evaluated in `S_ISSUE`:
  1. Key match: retrigger. `note_on` pulse only, state becomes `V_HELD`.
  2. `V_FREE` voice: `note_on` pulse.
  3. Oldest `V_REL` voice: `note_on` pulse.
  4. Oldest `V_HELD` voice: steal. `note_off` pulse in `S_ISSUE`, `note_on` pulse in `S_STEAL`.
- On every note-on assignment:
  - the target's key and period registers are loaded, its state becomes `V_HELD` and its age is cleared to 0;
  - every other non-free voice's age increments, saturating at 2^AGE_W-1.
- Note-off:
  - `V_HELD` voice with a matching key: `note_off` pulse, state becomes `V_REL`.
  - No match, or match only in `V_REL`: the event is dropped with no pulse. The FSM still passes through `S_ISSUE`.
- At most one `note_on` and one `note_off` bit is high in any cycle, never on the same voice in the same cycle.

## Timing
- Reset values:
  - `ev_ready`=1, `busy`=0.
  - All `voice_note_on` and `voice_note_off` bits = 0.
  - All `voice_period` fields = 0.
  - All voices `V_FREE`, ages 0, FSM `S_IDLE`.
- Event accepted at edge T:
  - `S_SCAN` occupies cycles T+1..T+N.
  - `S_ISSUE` is cycle T+N+1; its pulses are high during that cycle.
  - `voice_period` for the target is already valid in the cycle its `note_on` is high.
  - Steal: `note_off` at T+N+1, `note_on` at T+N+2.
  - `ev_ready` returns high at T+N+2, or at T+N+3 for a steal.
- `ev_ready` is low from the cycle after acceptance until return to `S_IDLE`. The upstream source must hold its event stable while `ev_valid & !ev_ready`.
- `voice_done` arriving during `S_SCAN` updates state immediately. The scan continues on live state; no snapshot is taken.
- `voice_done[i]` in the same cycle that voice i is chosen in `S_ISSUE`: the issue wins, and the voice ends in `V_HELD`.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Any pending pulse is lost, and no partial steal completes.

## Structure
- Package `voice_pkg` contains:
  - `voice_state_t` (`V_FREE`, `V_HELD`, `V_REL`);
  - `alloc_state_t` (`S_IDLE`, `S_SCAN`, `S_ISSUE`, `S_STEAL`);
  - the scan-result record type.
- Sub-module `voice_slot`: per-voice state, key, age and period registers, and done handling. Instantiated `NUM_VOICES` times.
- The top level holds the FSM, scan index, best-candidate registers and pulse generation.

## Test plan
- Reset, then note-on key 60, period 1000, N=4 → `voice_note_on`=4'b0001 at accept+5 with `voice_period[0]`=1000; `ev_ready` high at accept+6.
- Note-on keys 60, 62, 64, 65, then note-on 67 → steal voice 0: `voice_note_off`=4'b0001 at accept+5, `voice_note_on`=4'b0001 at accept+6, `voice_period[0]` updated.
- Note-on 60, note-off 60, note-on 62 with `voice_done` held low → 62 goes to voice 1 (free before releasing). Then fill the bank and note-on 70 → reuses `V_REL` voice 0 with no `note_off` pulse.
- Note-off key 50 with no voice holding it → no pulses; `ev_ready` returns at accept+6.
- Re-press a held key 60 → `note_on` on the same voice, no `note_off`, age reset to 0.
- Deassert `rst_b` during `S_SCAN` → outputs at reset values immediately, `ev_ready`=1 after release, no stray pulses.
